// File: rtl/ov5640_cfg_pkg.sv
// Shared definitions for the OV5640 register-init sequencer: FSM states,
// the I2C device address, the "wait" marker and the LUT entry layout.
package ov5640_cfg_pkg;

  localparam logic [7:0]  DEV_ADDR   = 8'h78;
  localparam logic [15:0] DELAY_MARK = 16'hFFFF;
  localparam int          ENTRY_W    = 24;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_LOAD,
    ST_START_LO,
    ST_START_HI,
    ST_CHECK,
    ST_SW_WAIT,
    ST_NEXT,
    ST_CAM_NEXT,
    ST_DONE
  } state_t;

  function automatic logic is_delay(input logic [15:0] reg_addr);
    return reg_addr == DELAY_MARK;
  endfunction

endpackage

// File: rtl/ov5640_reg_lut.sv
// Register table shared by both cameras: {reg_addr, reg_data} per index, plus
// a flag marking the final meaningful entry so the walk can stop early.
module ov5640_reg_lut
  import ov5640_cfg_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [15:0]      reg_addr_o,
  output logic [7:0]       reg_data_o,
  output logic             lut_last_o
);

  localparam int LUT_LEN = 16;

  logic [ENTRY_W-1:0] rom_word;

  always_comb begin
    rom_word = '0;
    case (int'(idx_i))
      0:  rom_word = 24'h3008_82;  // software reset
      1:  rom_word = {DELAY_MARK, 8'h00};
      2:  rom_word = 24'h3008_42;
      3:  rom_word = 24'h3103_03;
      4:  rom_word = 24'h3017_FF;
      5:  rom_word = 24'h3018_FF;
      6:  rom_word = 24'h3034_1A;
      7:  rom_word = 24'h3035_11;
      8:  rom_word = 24'h3036_46;
      9:  rom_word = 24'h3037_13;
      10: rom_word = 24'h3108_01;
      11: rom_word = 24'h3630_36;
      12: rom_word = 24'h3631_0E;
      13: rom_word = 24'h3632_E2;
      14: rom_word = 24'h3633_12;
      15: rom_word = 24'h4300_61;
      default: rom_word = '0;
    endcase
  end

  assign reg_addr_o = rom_word[23:8];
  assign reg_data_o = rom_word[7:0];
  assign lut_last_o = (int'(idx_i) >= LUT_LEN - 1);

endmodule

// File: rtl/ov5640_reg_seq.sv
// Walks the register LUT for camera 0 then camera 1, handing each word to the
// I2C engine through the start/tr_end handshake, with NACK retries.
module ov5640_reg_seq
  import ov5640_cfg_pkg::*;
#(
  parameter int  LUT_DEPTH = 256,
  parameter int  PWR_DELAY = 400,
  parameter int  SW_DELAY  = 100,
  parameter int  MAX_RETRY = 3,
  localparam int IDX_W     = $clog2(LUT_DEPTH)
) (
  input  logic             clock_i2c_i,
  input  logic             camera_rst_i,
  input  logic             tr_end_i,
  input  logic             ack_i,
  output logic [31:0]      i2c_data_o,
  output logic             start_o,
  output logic             camera1_o,
  output logic [IDX_W-1:0] reg_index_o,
  output logic             reg_conf_done_o,
  output logic             cfg_error_o
);

  localparam int CNT_MAX = (PWR_DELAY > SW_DELAY) ? PWR_DELAY : SW_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   PWR_LAST  = CNT_W'(PWR_DELAY - 1);
  localparam logic [CNT_W-1:0]   SW_LAST   = CNT_W'(SW_DELAY - 1);
  localparam logic [CNT_W-1:0]   LO_LAST   = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(LUT_DEPTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cam1_q, cam1_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;
  logic               nack_q, nack_d;
  logic               tr_end_dly_q;

  logic [15:0] lut_addr;
  logic [7:0]  lut_data;
  logic        lut_last;
  logic        tr_rise;

  ov5640_reg_lut #(.IDX_W(IDX_W)) u_lut (
    .idx_i      (idx_q),
    .reg_addr_o (lut_addr),
    .reg_data_o (lut_data),
    .lut_last_o (lut_last)
  );

  // A tr_end level left over from the previous word must not complete this one.
  assign tr_rise = tr_end_i & ~tr_end_dly_q;

  always_ff @(posedge clock_i2c_i or posedge camera_rst_i) begin
    if (camera_rst_i) begin
      state_q      <= ST_PWR_WAIT;
      cnt_q        <= '0;
      retry_q      <= '0;
      idx_q        <= '0;
      cam1_q       <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
      nack_q       <= 1'b0;
      tr_end_dly_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      idx_q        <= idx_d;
      cam1_q       <= cam1_d;
      data_q       <= data_d;
      err_q        <= err_d;
      nack_q       <= nack_d;
      tr_end_dly_q <= tr_end_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    cam1_d  = cam1_q;
    data_d  = data_q;
    err_d   = err_q;
    nack_d  = nack_q;
    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_d = '0;
        if (is_delay(lut_addr)) begin
          state_d = ST_SW_WAIT;
        end else begin
          data_d  = {DEV_ADDR, lut_addr, lut_data};
          state_d = ST_START_LO;
        end
      end
      // Two low cycles let the engine clear its counter, then drop tr_end.
      ST_START_LO: begin
        if (cnt_q == LO_LAST) begin
          cnt_d   = '0;
          state_d = ST_START_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_START_HI: begin
        if (tr_rise) begin
          nack_d  = ack_i;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!nack_q) begin
          retry_d = '0;
          state_d = ST_NEXT;
        end else if (retry_q != RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_START_LO;
        end else begin
          err_d   = 1'b1;
          retry_d = '0;
          state_d = ST_NEXT;
        end
      end
      ST_SW_WAIT: begin
        if (cnt_q == SW_LAST) begin
          cnt_d   = '0;
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_LAST || lut_last) begin
          state_d = ST_CAM_NEXT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_CAM_NEXT: begin
        if (!cam1_q) begin
          cam1_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_PWR_WAIT;
    endcase
  end

  always_comb begin
    start_o         = (state_q == ST_START_HI);
    reg_conf_done_o = (state_q == ST_DONE);
    i2c_data_o      = data_q;
    camera1_o       = cam1_q;
    reg_index_o     = idx_q;
    cfg_error_o     = err_q;
  end

endmodule

// File: tb/tb_ov5640_reg_seq.sv
// Directed bench for ov5640_reg_seq with a behavioural i2c_com model that
// completes each transfer a fixed time after start and NACKs on demand.
module tb_ov5640_reg_seq;

  localparam int          ENG_CYC = 4;
  localparam logic [31:0] W0  = 32'h7830_0882;
  localparam logic [31:0] W5  = 32'h7830_18FF;
  localparam logic [31:0] W6  = 32'h7830_341A;
  localparam logic [31:0] W15 = 32'h7843_0061;

  logic        clk = 1'b0;
  logic        camera_rst = 1'b1;
  logic        tr_end = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] i2c_data;
  logic        start;
  logic        camera1;
  logic [7:0]  reg_index;
  logic        reg_conf_done;
  logic        cfg_error;

  always #5 clk = ~clk;

  ov5640_reg_seq dut (
    .clock_i2c_i     (clk),
    .camera_rst_i    (camera_rst),
    .tr_end_i        (tr_end),
    .ack_i           (ack),
    .i2c_data_o      (i2c_data),
    .start_o         (start),
    .camera1_o       (camera1),
    .reg_index_o     (reg_index),
    .reg_conf_done_o (reg_conf_done),
    .cfg_error_o     (cfg_error)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  int          n_send, n_rise, nack_left, w5_cam0, cam_viol, data_viol, low_run, eng_cnt;
  logic        prev_start, prev_cam, hit;
  logic [31:0] data_at_rise;
  logic [31:0] data_log [64];
  logic [7:0]  idx_log  [64];
  logic        cam_log  [64];
  int          gap_log  [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    n_send = 0; n_rise = 0; w5_cam0 = 0; cam_viol = 0; data_viol = 0;
    for (int i = 0; i < 64; i++) begin
      data_log[i] = '0; idx_log[i] = '0; cam_log[i] = 1'b0; gap_log[i] = 0;
    end
  endtask

  // Monitor plus engine model, both acting on the falling edge.
  always @(negedge clk) begin
    if (camera_rst) begin
      low_run = 0; prev_start = 1'b0; prev_cam = 1'b0;
    end else begin
      if (camera1 != prev_cam && start) cam_viol++;
      if (start && prev_start && i2c_data != data_at_rise) data_viol++;
      if (start && !prev_start) begin
        if (n_rise < 64) gap_log[n_rise] = low_run;
        n_rise++;
        data_at_rise = i2c_data;
      end
      low_run    = start ? 0 : low_run + 1;
      prev_start = start;
      prev_cam   = camera1;
    end
    if (!start) begin
      eng_cnt = 0;
      tr_end  = 1'b0;
    end else if (!tr_end) begin
      if (eng_cnt == ENG_CYC - 1) begin
        ack = (i2c_data == W5) && (nack_left > 0);
        if (ack) nack_left--;
        tr_end = 1'b1;
        if (n_send < 64) begin
          data_log[n_send] = i2c_data;
          idx_log[n_send]  = reg_index;
          cam_log[n_send]  = camera1;
        end
        if (i2c_data == W5 && !camera1) w5_cam0++;
        $display("send %0d cam=%0b idx=%0d data=0x%08h ack=%0b", n_send, camera1, reg_index, i2c_data, ack);
        n_send++;
      end else begin
        eng_cnt++;
      end
    end
  end

  task automatic run_seq(input int budget);
    @(posedge clk);
    #1 camera_rst = 1'b1;
    nack_left = budget;
    clear_logs();
    repeat (2) @(posedge clk);
    #1 camera_rst = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (reg_conf_done) break;
    end
    #1;
  endtask

  initial begin
    nack_left = 0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_data", i2c_data, 32'd0);
    chk("rst_camera1", 32'(camera1), 32'd0);
    chk("rst_index", 32'(reg_index), 32'd0);
    chk("rst_done", 32'(reg_conf_done), 32'd0);
    chk("rst_error", 32'(cfg_error), 32'd0);

    // All words ACKed: power-up wait, delay entry, camera switch, completion.
    run_seq(0);
    chk("t1_pwr_gap", gap_log[0], 403);
    chk("t1_first_word", data_log[0], W0);
    chk("t1_delay_gap", gap_log[1], 107);
    chk("t1_delay_next_idx", 32'(idx_log[1]), 32'd2);
    chk("t1_normal_gap", gap_log[2], 5);
    chk("t1_cam_switch_gap", gap_log[15], 6);
    chk("t1_cam0_last_word", data_log[14], W15);
    chk("t1_cam1_first_word", data_log[15], W0);
    chk("t1_cam1_first_flag", 32'(cam_log[15]), 32'd1);
    chk("t1_cam1_first_idx", 32'(idx_log[15]), 32'd0);
    chk("t1_sends", n_send, 30);
    chk("t1_done", 32'(reg_conf_done), 32'd1);
    chk("t1_error", 32'(cfg_error), 32'd0);
    chk("t1_camera1", 32'(camera1), 32'd1);
    chk("t1_final_index", 32'(reg_index), 32'd15);
    chk("t1_cam_change_while_start", cam_viol, 0);
    chk("t1_data_unstable", data_viol, 0);

    // Word 5 NACKed once: single resend, no error.
    run_seq(1);
    chk("t2_w5_sends", w5_cam0, 2);
    chk("t2_retry_gap", gap_log[5], 3);
    chk("t2_resend_word", data_log[5], W5);
    chk("t2_next_idx", 32'(idx_log[6]), 32'd6);
    chk("t2_next_word", data_log[6], W6);
    chk("t2_error", 32'(cfg_error), 32'd0);
    chk("t2_sends", n_send, 31);
    chk("t2_done", 32'(reg_conf_done), 32'd1);

    // Word 5 always NACKed: 1 + MAX_RETRY sends per camera, error flagged.
    run_seq(1000);
    chk("t3_w5_sends", w5_cam0, 4);
    chk("t3_moved_on_idx", 32'(idx_log[8]), 32'd6);
    chk("t3_error", 32'(cfg_error), 32'd1);
    chk("t3_sends", n_send, 36);
    chk("t3_done", 32'(reg_conf_done), 32'd1);

    // Reset during a transfer: start drops at once, sequence restarts.
    @(posedge clk);
    #1 camera_rst = 1'b1;
    nack_left = 0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1 camera_rst = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (start && reg_index == 8'd3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t6_reached_start_hi", 32'(hit), 32'd1);
    #2 camera_rst = 1'b1;
    #1;
    chk("t6_start_dropped", 32'(start), 32'd0);
    chk("t6_index_cleared", 32'(reg_index), 32'd0);
    chk("t6_data_cleared", i2c_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 clear_logs();
    camera_rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (n_send >= 1) break;
    end
    #1;
    chk("t6_restart_sends", 32'(n_send >= 1), 32'd1);
    chk("t6_restart_gap", gap_log[0], 403);
    chk("t6_restart_word", data_log[0], W0);
    chk("t6_restart_idx", 32'(idx_log[0]), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
